wave_generator: RTL and testbench
=================================

Name: wave_generator

Overview:
Parametrised successor to the single-sine generator. It is a phase-accumulating waveform generator with selectable mode (sine, square, sawtooth, triangle), amplitude scaling and a glitch-free configuration handshake. New settings are applied only at a period boundary. It sits between the note/sequencer logic and the audio mixer, runs on the sample clock, and emits one registered sample per clock.

Parameters:
SAMPLE_RATE, 32000, sample-clock frequency in Hz; phase accumulator modulus.
FREQ_W, 14, width of the frequency input in Hz.
SAMPLE_W, 8, output sample width (unsigned, 0 = waveform minimum).
TABLE_AW, 7, log2 of samples per period (N = 2^TABLE_AW).
AMP_W, 8, amplitude input width.

Ports:
CLK_32KHz  in  1  sample clock; all logic is on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  run the generator; low forces idle.
cfg_valid  in  1  configuration request.
cfg_ready  out  1  configuration can be accepted.
cfg_freq  in  FREQ_W  requested frequency in Hz.
cfg_mode  in  2  0 = sine, 1 = square, 2 = sawtooth, 3 = triangle.
cfg_amp  in  AMP_W  amplitude; all-ones = full scale.
sample_out  out  SAMPLE_W  current sample, registered.
cycle_start  out  1  one-cycle pulse when sample_out carries index 0 of a new period.

Behaviour:
- Reset: phase, active frequency/mode/amplitude, pending flag, sample_out and cycle_start all go to 0. cfg_ready is 1. Any pending configuration is dropped. The same applies on reset mid-operation.
- Phase: range [0, SAMPLE_RATE), width ceil(log2(2*SAMPLE_RATE)).
  - While enable is high, each cycle: p = phase + freq_act.
  - If p >= SAMPLE_RATE: phase <= p - SAMPLE_RATE and wrap = 1. Otherwise phase <= p.
- Frequency clamp: freq_act = min(cfg_freq, SAMPLE_RATE/2), applied at load time. freq_act = 0 holds the phase (DC output at the index-0 value).
- Index: idx = floor(phase * N / SAMPLE_RATE), TABLE_AW bits. Intermediates are full precision; there is no overflow for legal parameters.
- Waveforms, M = 2^SAMPLE_W - 1:
  - sine[k] = round(M * (1 - cos(2πk/N)) / 2), a table built at elaboration. sine[0] = 0, sine[N/2] = M.
  - square = M when N/4 <= idx < 3N/4, else 0.
  - sawtooth = (idx * M) / (N - 1), floored.
  - triangle = (2*idx*M)/N for idx < N/2, else (2*(N - idx)*M)/N, both floored and saturated at M.
- Amplitude: sample_out <= (wave * (amp_act + 1)) >> AMP_W. A full-scale amplitude passes wave unchanged.
- Latency: sample_out reflects the phase register value of the previous cycle (1-cycle registered output).
- cycle_start is high in the cycle where sample_out shows the first sample after a wrap, i.e. a registered copy of wrap.
  - The first sample after enable rises also asserts cycle_start.
  - With freq_act = 0 it never re-pulses.
- Configuration handshake:
  - Accept when cfg_valid && cfg_ready; the triple is captured into a pending register and cfg_ready drops the next cycle.
  - The pending triple becomes active on the first wrap cycle; the accumulator add on that cycle still uses the old freq_act. The pending flag clears and cfg_ready returns to 1 the following cycle.
  - If enable is low or freq_act == 0 at acceptance, the triple is applied on the next clock and the pending stage is bypassed.
  - A valid request while cfg_ready is low is held by the master (valid/ready rules). It is not dropped, and the master must not change the data while waiting.
  - Wrap and acceptance in the same cycle: the newly accepted triple waits for the next wrap. There is no double-apply.
- Idle: when enable is low, phase <= 0 and sample_out <= 0 on the next clock, cycle_start = 0, and the active configuration is retained.

Test Plan:
- Reset, then enable = 1 with cfg {freq = 1000, sine, amp = 255} → idx steps by 4. cycle_start pulses every 32 cycles. Samples at idx 0/32/64 are 0/128/255.
- freq = 1000 active; request freq = 2000 mid-period → cfg_ready = 0 until the wrap. The old period completes at 32 samples, then the period is 16 samples with idx steps of 8.
- cfg_freq = 16383 → clamped to 16000. idx alternates 0, 64; sine output alternates 0, 255; cycle_start every 2 cycles.
- Mode sweep at freq = 1000, amp = 255:
  - square: 0 for idx 0..28, 255 for idx 32..92, 0 for idx 96..124.
  - sawtooth at idx 64: 128.
  - triangle at idx 32/64/96: 127/255/127.
- amp = 127, sine, idx 64 → sample_out = 127.
- Assert reset_n low mid-period with a pending config → all outputs 0 and cfg_ready = 1. After release with enable = 1, output holds 0 (freq_act = 0) until a new cfg is applied on the next clock.

Source files
------------

// File: rtl/wave_generator.sv
// Phase-accumulating waveform generator: sine/square/sawtooth/triangle with
// amplitude scaling and a configuration handshake that is applied only at a
// period boundary. Emits one registered sample per sample clock.
module wave_generator #(
  parameter int SAMPLE_RATE = 32000,
  parameter int FREQ_W      = 14,
  parameter int SAMPLE_W    = 8,
  parameter int TABLE_AW    = 7,
  parameter int AMP_W       = 8
) (
  input  logic                CLK_32KHz,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [FREQ_W-1:0]   cfg_freq,
  input  logic [1:0]          cfg_mode,
  input  logic [AMP_W-1:0]    cfg_amp,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                cycle_start
);

  localparam int N    = 2 ** TABLE_AW;
  localparam int M    = 2 ** SAMPLE_W - 1;
  localparam int PH_W = $clog2(2 * SAMPLE_RATE);
  localparam int IX_W = PH_W + TABLE_AW;
  localparam int WW   = SAMPLE_W + TABLE_AW + 2;
  localparam logic [PH_W-1:0] SR   = PH_W'(SAMPLE_RATE);
  localparam logic [PH_W-1:0] HALF = PH_W'(SAMPLE_RATE / 2);

  typedef struct packed {
    logic [PH_W-1:0]  freq;
    logic [1:0]       mode;
    logic [AMP_W-1:0] amp;
  } cfg_t;

  // Raised-cosine sine table, evaluated at elaboration time.
  function automatic int sine_val(input int k);
    real a;
    a = real'(M) * (1.0 - $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N))) / 2.0;
    return $rtoi(a + 0.5 + 1.0e-9);
  endfunction

  logic [N-1:0][SAMPLE_W-1:0] sine_tbl;
  for (genvar gk = 0; gk < N; gk++) begin : g_sine
    localparam int V = sine_val(gk);
    assign sine_tbl[gk] = SAMPLE_W'(V);
  end

  logic [PH_W-1:0]     phase, p;
  logic                wrap, wrap_q, pend, en_q, accept, bypass;
  cfg_t                act, pend_cfg, req;
  logic [TABLE_AW-1:0] idx;
  logic [WW-1:0]       saw_w, tri_w, tri_sat;
  logic [SAMPLE_W-1:0] wave;
  logic [SAMPLE_W+AMP_W:0] scaled;

  assign cfg_ready = ~pend;
  assign accept    = cfg_valid & cfg_ready;
  assign bypass    = ~enable | (act.freq == '0);

  // Clamp the requested frequency to Nyquist as it is captured.
  always_comb begin
    req.freq = (PH_W'(cfg_freq) > HALF) ? HALF : PH_W'(cfg_freq);
    req.mode = cfg_mode;
    req.amp  = cfg_amp;
  end

  // Accumulator step; sum stays below 1.5*SAMPLE_RATE so PH_W bits suffice.
  always_comb begin
    p    = phase + act.freq;
    wrap = enable & (p >= SR);
  end

  // Phase-to-index and waveform shaping from the current phase register.
  always_comb begin
    idx     = TABLE_AW'(({phase, TABLE_AW'(0)}) / IX_W'(SAMPLE_RATE));
    saw_w   = (WW'(idx) * WW'(M)) / WW'(N - 1);
    if (int'(idx) < N / 2) tri_w = (WW'(idx) * WW'(M)) >> (TABLE_AW - 1);
    else                   tri_w = ((WW'(N) - WW'(idx)) * WW'(M)) >> (TABLE_AW - 1);
    tri_sat = (tri_w > WW'(M)) ? WW'(M) : tri_w;
    case (act.mode)
      2'd0:    wave = sine_tbl[idx];
      2'd1:    wave = (int'(idx) >= N / 4 && int'(idx) < 3 * N / 4) ? SAMPLE_W'(M) : '0;
      2'd2:    wave = SAMPLE_W'(saw_w);
      default: wave = SAMPLE_W'(tri_sat);
    endcase
    scaled = (SAMPLE_W + AMP_W + 1)'(wave) * ((SAMPLE_W + AMP_W + 1)'(act.amp) + 1'b1);
  end

  // Phase accumulator plus active/pending configuration registers.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      wrap_q   <= 1'b0;
      act      <= '0;
      pend_cfg <= '0;
      pend     <= 1'b0;
    end else begin
      if (enable) begin
        phase  <= wrap ? p - SR : p;
        wrap_q <= wrap;
      end else begin
        phase  <= '0;
        wrap_q <= 1'b0;
      end
      // accept implies !pend, so the branches below never collide
      if (accept && bypass) begin
        act <= req;
      end else if (accept) begin
        pend_cfg <= req;
        pend     <= 1'b1;
      end else if (pend && wrap) begin
        act  <= pend_cfg;
        pend <= 1'b0;
      end
    end
  end

  // Registered sample and period-start marker aligned with index 0.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      sample_out  <= '0;
      cycle_start <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      en_q <= enable;
      if (enable) begin
        sample_out  <= SAMPLE_W'(scaled >> AMP_W);
        cycle_start <= wrap_q | ~en_q;
      end else begin
        sample_out  <= '0;
        cycle_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// Directed bench for wave_generator: sine timing, mid-period reconfiguration,
// Nyquist clamp, mode sweep, amplitude and reset with a pending request.
module tb_wave_generator;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [13:0] cfg_freq = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_amp = '0;
  logic [7:0] sample_out;
  logic       cycle_start;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  wave_generator dut (
    .CLK_32KHz(clk), .reset_n(reset_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_freq(cfg_freq),
    .cfg_mode(cfg_mode), .cfg_amp(cfg_amp),
    .sample_out(sample_out), .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  // Reconfigure while idle (applied on the next clock), then restart.
  task automatic run_cfg(input logic [13:0] f, input logic [1:0] m, input logic [7:0] a);
    enable = 1'b0;
    step();
    chk("idle_sample", sample_out, 0);
    chk("idle_cs", cycle_start, 0);
    cfg_valid = 1'b1; cfg_freq = f; cfg_mode = m; cfg_amp = a;
    step();
    cfg_valid = 1'b0;
    chk("bypass_ready", cfg_ready, 1);
    enable = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #22;
    chk("rst_sample", sample_out, 0);
    chk("rst_cs", cycle_start, 0);
    chk("rst_ready", cfg_ready, 1);
    reset_n = 1'b1;
    step();

    // sine @1000 Hz: index advances by 4, period 32
    cfg_valid = 1'b1; cfg_freq = 14'd1000; cfg_mode = 2'd0; cfg_amp = 8'd255;
    step();
    cfg_valid = 1'b0;
    chk("cfg_ready_idle", cfg_ready, 1);
    enable = 1'b1;
    cyc = 0;
    goto(1);  chk("sin_i0", sample_out, 0);   chk("sin_cs_first", cycle_start, 1);
    goto(2);  chk("sin_cs_off", cycle_start, 0);
    goto(9);  chk("sin_i32", sample_out, 128);
    goto(17); chk("sin_i64", sample_out, 255);
    goto(32); chk("sin_cs_pre", cycle_start, 0);
    goto(33); chk("sin_wrap_i0", sample_out, 0); chk("sin_cs_wrap", cycle_start, 1);

    // request 2000 Hz mid-period; applied at the wrap on cycle 64
    chk("ready_before_req", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_freq = 14'd2000;
    step();
    cfg_valid = 1'b0;
    chk("ready_pending", cfg_ready, 0);
    goto(63); chk("ready_still_pending", cfg_ready, 0);
    goto(64); chk("ready_after_apply", cfg_ready, 1);
    goto(65); chk("f2k_i0", sample_out, 0);   chk("f2k_cs", cycle_start, 1);
    goto(69); chk("f2k_i32", sample_out, 128);
    goto(73); chk("f2k_i64", sample_out, 255);
    goto(80); chk("f2k_cs_pre", cycle_start, 0);
    goto(81); chk("f2k_cs_16", cycle_start, 1);

    // 16383 Hz clamps to 16000: index alternates 0/64
    cfg_valid = 1'b1; cfg_freq = 14'd16383;
    step();
    cfg_valid = 1'b0;
    chk("clamp_pending", cfg_ready, 0);
    goto(97);  chk("clamp_s0", sample_out, 0);   chk("clamp_cs0", cycle_start, 1);
    goto(98);  chk("clamp_s1", sample_out, 255); chk("clamp_cs1", cycle_start, 0);
    goto(99);  chk("clamp_s2", sample_out, 0);   chk("clamp_cs2", cycle_start, 1);
    goto(100); chk("clamp_s3", sample_out, 255);

    // square
    run_cfg(14'd1000, 2'd1, 8'd255);
    goto(8);  chk("sq_i28", sample_out, 0);
    goto(9);  chk("sq_i32", sample_out, 255);
    goto(24); chk("sq_i92", sample_out, 255);
    goto(25); chk("sq_i96", sample_out, 0);

    // sawtooth
    run_cfg(14'd1000, 2'd2, 8'd255);
    goto(17); chk("saw_i64", sample_out, 128);
    goto(32); chk("saw_i124", sample_out, 248);

    // triangle
    run_cfg(14'd1000, 2'd3, 8'd255);
    goto(9);  chk("tri_i32", sample_out, 127);
    goto(17); chk("tri_i64", sample_out, 255);
    goto(25); chk("tri_i96", sample_out, 127);

    // half amplitude
    run_cfg(14'd1000, 2'd0, 8'd127);
    goto(17); chk("amp127_i64", sample_out, 127);

    // reset mid-period with a pending request
    run_cfg(14'd1000, 2'd0, 8'd255);
    goto(5);
    cfg_valid = 1'b1; cfg_freq = 14'd3000;
    step();
    cfg_valid = 1'b0;
    chk("pre_rst_pending", cfg_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_sample", sample_out, 0);
    chk("mid_rst_cs", cycle_start, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    #1 reset_n = 1'b1;
    step();
    step();
    chk("post_rst_dc", sample_out, 0);
    step();
    chk("post_rst_dc2", sample_out, 0);
    cfg_valid = 1'b1; cfg_freq = 14'd1000; cfg_mode = 2'd0; cfg_amp = 8'd255;
    step();
    cfg_valid = 1'b0;
    chk("post_rst_ready", cfg_ready, 1);
    cyc = 0;
    goto(9);  chk("post_rst_i32", sample_out, 128);
    goto(17); chk("post_rst_i64", sample_out, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
